// File: rtl/bus_drvr_fifo.sv
// Per-driver FIFO pair between a PE and one bus-arbiter driver port:
// TX carries PE words to the arbiter, RX carries arbiter deliveries to the PE.

module bus_drvr_fifo_q #(
  parameter int bits  = 32,
  parameter int depth = 16,
  localparam int aw   = $clog2(depth)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [bits-1:0] wdata,
  input  logic            rd,
  output logic [bits-1:0] rdata,
  output logic [aw:0]     count,
  output logic            ovf
);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

  logic [bits-1:0] mem [depth];
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;
  logic            full;
  logic            nempty;
  logic            rd_eff;
  logic            wr_acc;

  assign full   = (count == full_count);
  assign nempty = (count != '0);
  assign rd_eff = rd & nempty;
  // A read in the same cycle frees the slot, so a full queue still accepts.
  assign wr_acc = wr & (~full | rd_eff);
  assign rdata  = nempty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr & ~wr_acc) ovf <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the count gates what the read port exposes,
  // so stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wdata;
  end
endmodule

module bus_drvr_fifo #(
  parameter int bits  = 32,
  parameter int depth = 16,
  localparam int aw   = $clog2(depth)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            pndng,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            pe_wr,
  input  logic [bits-1:0] pe_wdata,
  output logic            pe_full,
  input  logic            pe_rd,
  output logic [bits-1:0] pe_rdata,
  output logic            pe_valid,
  output logic [aw:0]     tx_count,
  output logic [aw:0]     rx_count,
  output logic            tx_ovf,
  output logic            rx_ovf
);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

  bus_drvr_fifo_q #(.bits(bits), .depth(depth)) u_tx (
    .clk   (clk),
    .reset (reset),
    .wr    (pe_wr),
    .wdata (pe_wdata),
    .rd    (pop),
    .rdata (D_pop),
    .count (tx_count),
    .ovf   (tx_ovf)
  );

  // The arbiter cannot be stalled, so RX push is always offered.
  bus_drvr_fifo_q #(.bits(bits), .depth(depth)) u_rx (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (D_push),
    .rd    (pe_rd),
    .rdata (pe_rdata),
    .count (rx_count),
    .ovf   (rx_ovf)
  );

  assign pndng    = (tx_count != '0);
  assign pe_full  = (tx_count == full_count);
  assign pe_valid = (rx_count != '0);
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Self-checking bench for bus_drvr_fifo: directed test-plan steps plus random
// traffic, compared every cycle against a queue-based model.

module tb_bus_drvr_fifo;
  localparam int bits  = 32;
  localparam int depth = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pndng, pe_full, pe_valid, tx_ovf, rx_ovf;
  logic            pop = 1'b0, push = 1'b0, pe_wr = 1'b0, pe_rd = 1'b0;
  logic [bits-1:0] D_pop, pe_rdata;
  logic [bits-1:0] D_push = '0, pe_wdata = '0;
  logic [4:0]      tx_count, rx_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          tx_ovf_m, rx_ovf_m;

  bus_drvr_fifo #(.bits(bits), .depth(depth)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .pop      (pop),
    .D_pop    (D_pop),
    .push     (push),
    .D_push   (D_push),
    .pe_wr    (pe_wr),
    .pe_wdata (pe_wdata),
    .pe_full  (pe_full),
    .pe_rd    (pe_rd),
    .pe_rdata (pe_rdata),
    .pe_valid (pe_valid),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .tx_ovf   (tx_ovf),
    .rx_ovf   (rx_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pndng",    32'(pndng),    32'(tx_q.size() != 0));
    check("pe_full",  32'(pe_full),  32'(tx_q.size() == depth));
    check("tx_count", 32'(tx_count), 32'(tx_q.size()));
    check("D_pop",    D_pop,         (tx_q.size() != 0) ? tx_q[0] : 32'h0);
    check("tx_ovf",   32'(tx_ovf),   32'(tx_ovf_m));
    check("pe_valid", 32'(pe_valid), 32'(rx_q.size() != 0));
    check("rx_count", 32'(rx_count), 32'(rx_q.size()));
    check("pe_rdata", pe_rdata,      (rx_q.size() != 0) ? rx_q[0] : 32'h0);
    check("rx_ovf",   32'(rx_ovf),   32'(rx_ovf_m));
  endtask

  // One clock edge: apply the queue rules to the model, then compare.
  task automatic step();
    bit pop_ok, wr_ok, rd_ok, push_ok;
    @(posedge clk);
    #1;
    pop_ok  = pop && (tx_q.size() != 0);
    wr_ok   = pe_wr && ((tx_q.size() < depth) || pop_ok);
    rd_ok   = pe_rd && (rx_q.size() != 0);
    push_ok = push && ((rx_q.size() < depth) || rd_ok);
    if (pe_wr && !wr_ok) tx_ovf_m = 1'b1;
    if (push && !push_ok) rx_ovf_m = 1'b1;
    if (pop_ok) void'(tx_q.pop_front());
    if (wr_ok) tx_q.push_back(pe_wdata);
    if (rd_ok) void'(rx_q.pop_front());
    if (push_ok) rx_q.push_back(D_push);
    check_all();
  endtask

  task automatic idle_inputs();
    pop = 0; push = 0; pe_wr = 0; pe_rd = 0; D_push = '0; pe_wdata = '0;
  endtask

  task automatic rand_inputs();
    pop = 1'($urandom); push = 1'($urandom); pe_wr = 1'($urandom); pe_rd = 1'($urandom);
    D_push = $urandom; pe_wdata = $urandom;
  endtask

  // Assert reset between edges, wiggle inputs while held, release between edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    tx_q.delete(); rx_q.delete(); tx_ovf_m = 0; rx_ovf_m = 0;
    check_all();
    repeat (3) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check_all();
    end
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    // Reset / idle
    do_reset();
    repeat (2) step();

    // TX fill 0x00..0x0F, then a dropped 17th write
    for (int i = 0; i < depth; i++) begin
      pe_wr = 1; pe_wdata = 32'(i);
      step();
    end
    check("tx_full_after_16", 32'(pe_full), 32'h1);
    pe_wdata = 32'hAA;
    step();
    pe_wr = 0;
    check("tx_ovf_17th", 32'(tx_ovf), 32'h1);
    check("tx_count_17th", 32'(tx_count), 32'd16);
    for (int i = 0; i < depth; i++) begin
      check("tx_drain_seq", D_pop, 32'(i));
      pop = 1;
      step();
    end
    pop = 0;
    check("tx_pndng_drained", 32'(pndng), 32'h0);
    step();  // pop-free cycle, and the earlier empty-pop case follows

    // Pop on empty is ignored
    pop = 1; step(); pop = 0;

    // Full boundary: write + pop together
    do_reset();
    for (int i = 0; i < depth; i++) begin
      pe_wr = 1; pe_wdata = $urandom;
      step();
    end
    pe_wr = 1; pe_wdata = 32'h55; pop = 1;
    step();
    pe_wr = 0;
    check("full_wrpop_count", 32'(tx_count), 32'd16);
    check("full_wrpop_ovf", 32'(tx_ovf), 32'h0);
    for (int i = 0; i < depth; i++) begin
      if (i == depth - 1) check("full_wrpop_last", D_pop, 32'h55);
      step();
    end
    pop = 0;
    // Empty boundary: write + pop together
    pe_wr = 1; pop = 1; pe_wdata = 32'h3C;
    step();
    pe_wr = 0; pop = 0;
    check("empty_wrpop_count", 32'(tx_count), 32'd1);
    check("empty_wrpop_data", D_pop, 32'h3C);
    pop = 1; step(); pop = 0;

    // RX overflow
    for (int i = 0; i <= depth; i++) begin
      push = 1; D_push = 32'h100 + 32'(i);
      step();
    end
    push = 0;
    check("rx_count_ovf", 32'(rx_count), 32'd16);
    check("rx_ovf_set", 32'(rx_ovf), 32'h1);
    for (int i = 0; i < depth; i++) begin
      check("rx_read_seq", pe_rdata, 32'h100 + 32'(i));
      pe_rd = 1;
      step();
    end
    pe_rd = 0;
    check("rx_empty_after", 32'(pe_valid), 32'h0);

    // Wrap-around with occupancy held in 3..5 on both queues
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pe_wr = 1; push = 1; pe_wdata = $urandom; D_push = $urandom;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      if (tx_q.size() <= 3) pop = 0;
      if (tx_q.size() >= 5) pe_wr = 0;
      if (rx_q.size() <= 3) pe_rd = 0;
      if (rx_q.size() >= 5) push = 0;
      step();
    end
    idle_inputs();
    // Mostly-writing, then mostly-reading random traffic to hit full/empty
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      pe_wr = ($urandom_range(0, 3) != 0) ^ (i >= 150);
      push  = ($urandom_range(0, 3) != 0) ^ (i >= 150);
      pop   = ($urandom_range(0, 3) == 0) ^ (i >= 150);
      pe_rd = ($urandom_range(0, 3) == 0) ^ (i >= 150);
      step();
    end
    idle_inputs();

    // Reset mid-operation with 5 words queued
    while (tx_q.size() != 0) begin pop = 1; step(); end
    pop = 0;
    for (int i = 0; i < 5; i++) begin
      pe_wr = 1; pe_wdata = $urandom;
      step();
    end
    pe_wr = 0;
    check("pre_reset_count", 32'(tx_count), 32'd5);
    do_reset();
    pe_wr = 1; pe_wdata = 32'h77;
    step();
    pe_wr = 0;
    check("post_reset_data", D_pop, 32'h77);
    check("post_reset_count", 32'(tx_count), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
